// File: rtl/tx_uart.sv
// Runtime-configurable UART transmitter.
// Each accepted write sends one character framed as start, 5-8 data bits (LSB first),
// optional parity, and one or two stop bits. Every bit is held for N clocks, where N
// comes from the setup word. Break generation and CTS gating of new writes are supported.
module tx_uart #(
  parameter int unsigned TIMING_BITS = 24
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic [30:0] i_setup,
  input  logic        i_break,
  input  logic        i_wr,
  input  logic [7:0]  i_data,
  input  logic        i_cts_n,
  output logic        o_uart_tx,
  output logic        o_busy
);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop,
    StBreak
  } state_e;

  state_e                 state_q;
  logic [TIMING_BITS-1:0] cnt_q;        // clocks left in the current bit, minus one
  logic [TIMING_BITS-1:0] n_m1_q;       // latched clocks-per-bit minus one
  logic [2:0]             bits_m1_q;    // latched data-bit count minus one
  logic [2:0]             bits_left_q;  // data bits still to send after the current one
  logic [7:0]             sh_q;         // data shift register, LSB goes out next
  logic                   par_en_q;
  logic                   par_fix_q;
  logic                   par_sel_q;    // fixed parity value, or 1 = odd parity
  logic                   stop2_q;      // a further stop bit follows the current one
  logic                   par_q;        // XOR of data bits sent so far
  logic                   tx_q;
  logic                   busy_q;

  logic [TIMING_BITS-1:0] n_raw;
  logic [TIMING_BITS-1:0] n_cur_m1;
  logic [2:0]             k_cur_m1;
  logic                   cts_block;
  logic                   accept;
  logic                   par_bit;
  logic                   last_stop;

  // Setup decode for the write being accepted; N below 2 behaves as 1.
  assign n_raw     = i_setup[TIMING_BITS-1:0];
  assign n_cur_m1  = (n_raw < TIMING_BITS'(2)) ? '0 : n_raw - TIMING_BITS'(1);
  assign k_cur_m1  = 3'd7 - {1'b0, i_setup[29:28]};

  assign cts_block = ~i_setup[30] & i_cts_n;

  // Break and flow control act on the current cycle; the frame part is registered.
  // Reset gating keeps the outputs idle while reset is held, even under a break.
  assign o_busy    = i_reset_n & (busy_q | i_break | cts_block);
  assign o_uart_tx = ~i_reset_n | (tx_q & ~i_break);

  assign accept    = i_wr & ~o_busy;

  // Even parity repeats the data XOR, odd parity inverts it.
  assign par_bit   = par_fix_q ? par_sel_q : (par_q ^ par_sel_q);
  assign last_stop = (state_q == StStop) & ~stop2_q;

  // Transmit FSM. busy_q drops during the final clock of the last stop bit so a write
  // taken in that clock starts its start bit with no idle gap between frames.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      n_m1_q      <= '0;
      bits_m1_q   <= '0;
      bits_left_q <= '0;
      sh_q        <= '0;
      par_en_q    <= 1'b0;
      par_fix_q   <= 1'b0;
      par_sel_q   <= 1'b0;
      stop2_q     <= 1'b0;
      par_q       <= 1'b0;
      tx_q        <= 1'b1;
      busy_q      <= 1'b0;
    end else if (i_break) begin
      // Abort everything; the mark time after release uses the live bit period.
      state_q <= StBreak;
      cnt_q   <= n_cur_m1;
      tx_q    <= 1'b1;
      busy_q  <= 1'b1;
    end else if (accept) begin
      state_q   <= StStart;
      cnt_q     <= n_cur_m1;
      n_m1_q    <= n_cur_m1;
      bits_m1_q <= k_cur_m1;
      sh_q      <= i_data;
      par_en_q  <= i_setup[26];
      par_fix_q <= i_setup[25];
      par_sel_q <= i_setup[24];
      stop2_q   <= i_setup[27];
      par_q     <= 1'b0;
      tx_q      <= 1'b0;
      busy_q    <= 1'b1;
    end else if (state_q == StIdle) begin
      tx_q   <= 1'b1;
      busy_q <= 1'b0;
    end else if (state_q == StBreak) begin
      tx_q <= 1'b1;
      if (cnt_q == '0) begin
        state_q <= StIdle;
        busy_q  <= 1'b0;
      end else begin
        cnt_q <= cnt_q - TIMING_BITS'(1);
      end
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - TIMING_BITS'(1);
      if (last_stop && (cnt_q == TIMING_BITS'(1))) begin
        busy_q <= 1'b0;
      end
    end else begin
      cnt_q <= n_m1_q;
      unique case (state_q)
        StStart: begin
          state_q     <= StData;
          tx_q        <= sh_q[0];
          par_q       <= par_q ^ sh_q[0];
          sh_q        <= {1'b0, sh_q[7:1]};
          bits_left_q <= bits_m1_q;
        end
        StData: begin
          if (bits_left_q != 3'd0) begin
            tx_q        <= sh_q[0];
            par_q       <= par_q ^ sh_q[0];
            sh_q        <= {1'b0, sh_q[7:1]};
            bits_left_q <= bits_left_q - 3'd1;
          end else if (par_en_q) begin
            state_q <= StParity;
            tx_q    <= par_bit;
          end else begin
            state_q <= StStop;
            tx_q    <= 1'b1;
            // One-clock bits: the single stop bit is already the final clock.
            if (!stop2_q && (n_m1_q == '0)) begin
              busy_q <= 1'b0;
            end
          end
        end
        StParity: begin
          state_q <= StStop;
          tx_q    <= 1'b1;
          if (!stop2_q && (n_m1_q == '0)) begin
            busy_q <= 1'b0;
          end
        end
        StStop: begin
          tx_q <= 1'b1;
          if (stop2_q) begin
            stop2_q <= 1'b0;
            if (n_m1_q == '0) begin
              busy_q <= 1'b0;
            end
          end else begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= StIdle;
          tx_q    <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tx_uart.sv
// Bench for tx_uart: a waveform-queue model predicts the line and busy on every cycle,
// and directed sections pin the model with hand-computed frames and timings.
module tb_tx_uart;

  logic        clk;
  logic        rst_n;
  logic [30:0] setup;
  logic        brk;
  logic        wr;
  logic [7:0]  data;
  logic        cts_n;
  logic        tx;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int cyc_fail_prints = 0;

  // Model state: future line levels, one entry per clock, plus post-break mark clocks.
  bit line_q[$];
  int mark;

  tx_uart #(
    .TIMING_BITS(24)
  ) dut (
    .i_clk    (clk),
    .i_reset_n(rst_n),
    .i_setup  (setup),
    .i_break  (brk),
    .i_wr     (wr),
    .i_data   (data),
    .i_cts_n  (cts_n),
    .o_uart_tx(tx),
    .o_busy   (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic int bit_clocks(input logic [30:0] s);
    return (s[23:0] < 24'd2) ? 1 : int'(s[23:0]);
  endfunction

  // Expand one character into its per-clock line levels.
  task automatic push_frame(input logic [30:0] s, input logic [7:0] d);
    bit bits[$];
    int n;
    int k;
    int ones;
    n    = bit_clocks(s);
    k    = 8 - int'(s[29:28]);
    ones = 0;
    bits.push_back(1'b0);
    for (int i = 0; i < k; i++) begin
      bits.push_back(d[i]);
      ones += int'(d[i]);
    end
    if (s[26]) begin
      if (s[25]) bits.push_back(s[24]);
      else if (s[24]) bits.push_back((ones % 2) == 0);
      else bits.push_back((ones % 2) == 1);
    end
    bits.push_back(1'b1);
    if (s[27]) bits.push_back(1'b1);
    foreach (bits[i]) begin
      repeat (n) line_q.push_back(bits[i]);
    end
  endtask

  // Per-cycle compare on the falling edge, then advance the model to the next cycle.
  always @(negedge clk) begin
    bit exp_tx;
    bit exp_busy;
    if (!rst_n) begin
      line_q.delete();
      mark     = 0;
      exp_tx   = 1'b1;
      exp_busy = 1'b0;
    end else begin
      exp_busy = brk || (!setup[30] && cts_n) || (line_q.size() > 1) || (mark > 0);
      exp_tx   = brk ? 1'b0 : ((line_q.size() > 0) ? line_q[0] : 1'b1);
    end
    checks += 2;
    if (tx !== exp_tx || busy !== exp_busy) begin
      errors++;
      if (cyc_fail_prints < 20) begin
        cyc_fail_prints++;
        $display("FAIL cycle_compare: tx=%b busy=%b, expected tx=%b busy=%b (t=%0t)",
                 tx, busy, exp_tx, exp_busy, $time);
      end
    end
    if (rst_n) begin
      if (brk) begin
        line_q.delete();
        mark = bit_clocks(setup);
      end else begin
        if (line_q.size() > 0) void'(line_q.pop_front());
        else if (mark > 0) mark--;
        if (wr && !exp_busy) push_frame(setup, data);
      end
    end
  end

  task automatic wait_idle(input int budget);
    int c;
    c = 0;
    while (busy && c < budget) begin
      tick(1);
      c++;
    end
    chk("idle_timeout", busy, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [9:0]  exp_i;
    logic [10:0] exp_7e2;
    string       msg;
    int          idx;
    int          cyc;
    int          first_acc;
    int          last_acc;
    int          brk_hold;

    rst_n = 1'b0;
    setup = 31'd868;
    brk   = 1'b0;
    wr    = 1'b0;
    data  = 8'h00;
    cts_n = 1'b0;
    #1;
    chk("reset_tx", tx, 1'b1);
    chk("reset_busy", busy, 1'b0);
    tick(3);
    rst_n = 1'b1;
    tick(3);
    chk("post_reset_tx", tx, 1'b1);
    chk("post_reset_busy", busy, 1'b0);

    // 8N1, N=868, 'I': sample the middle of each bit.
    exp_i = 10'b1010010010;
    data  = 8'h49;
    wr    = 1'b1;
    tick(1);
    wr    = 1'b0;
    chk("8n1_busy_after_accept", busy, 1'b1);
    tick(433);
    for (int b = 0; b < 10; b++) begin
      chk($sformatf("8n1_bit%0d", b), tx, exp_i[b]);
      if (b < 9) tick(868);
    end
    tick(8679 - 8246);
    chk("8n1_busy_before_end", busy, 1'b1);
    tick(1);
    chk("8n1_ready_at_8680", busy, 1'b0);
    wait_idle(10);

    // 7E2, N=4, data 0xFF: upper bit dropped, parity 1.
    exp_7e2 = 11'b11111111110;
    setup   = 31'h1C00_0004;
    data    = 8'hFF;
    wr      = 1'b1;
    tick(1);
    wr      = 1'b0;
    tick(1);
    for (int b = 0; b < 11; b++) begin
      chk($sformatf("7e2_bit%0d", b), tx, exp_7e2[b]);
      if (b < 10) tick(4);
    end
    tick(43 - 42);
    chk("7e2_busy_before_end", busy, 1'b1);
    tick(1);
    chk("7e2_ready_at_44", busy, 1'b0);
    wait_idle(10);

    // Back-to-back message with write held, data advanced on each acceptance.
    msg       = "INTRUDER ALERT\r\n";
    setup     = 31'd16;
    idx       = 0;
    cyc       = 0;
    first_acc = -1;
    last_acc  = -1;
    data      = msg[0];
    wr        = 1'b1;
    #1;
    while (idx < 16 && cyc < 4000) begin
      if (!busy) begin
        if (idx == 0) first_acc = cyc;
        if (idx == 15) last_acc = cyc;
        idx++;
        tick(1);
        if (idx < 16) data = msg[idx];
      end else begin
        tick(1);
      end
      cyc++;
    end
    wr = 1'b0;
    chk("b2b_count", idx, 16);
    chk("b2b_span", last_acc - first_acc, 15 * 160);
    wait_idle(400);

    // Flow control: CTS deasserted blocks writes.
    cts_n = 1'b1;
    data  = 8'h5A;
    wr    = 1'b1;
    tick(20);
    chk("cts_block_busy", busy, 1'b1);
    chk("cts_block_line", tx, 1'b1);
    cts_n = 1'b0;
    #1;
    chk("cts_ready", busy, 1'b0);
    tick(1);
    wr = 1'b0;
    chk("cts_accept_busy", busy, 1'b1);
    chk("cts_start_bit", tx, 1'b0);
    wait_idle(400);

    // Break in the middle of data bit 3, then mark time of N clocks.
    setup = 31'd8;
    data  = 8'hFF;
    wr    = 1'b1;
    tick(1);
    wr    = 1'b0;
    tick(26);
    chk("brk_pre_line", tx, 1'b1);
    brk = 1'b1;
    #1;
    chk("brk_line", tx, 1'b0);
    chk("brk_busy", busy, 1'b1);
    tick(5);
    brk = 1'b0;
    #1;
    chk("brk_release_line", tx, 1'b1);
    chk("brk_release_busy", busy, 1'b1);
    tick(7);
    chk("brk_mark_busy", busy, 1'b1);
    tick(1);
    chk("brk_mark_done", busy, 1'b0);

    // Asynchronous reset in mid-frame.
    data = 8'h00;
    wr   = 1'b1;
    tick(1);
    wr   = 1'b0;
    tick(20);
    chk("rst_pre_line", tx, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_line", tx, 1'b1);
    chk("rst_mid_busy", busy, 1'b0);
    tick(2);
    rst_n = 1'b1;
    tick(3);
    chk("rst_after_line", tx, 1'b1);
    chk("rst_after_busy", busy, 1'b0);

    // Random traffic: setup changes mid-frame, CTS toggles, breaks, simultaneous writes.
    brk_hold = 0;
    for (int c = 0; c < 5000; c++) begin
      if ($urandom_range(0, 49) == 0)
        setup = {1'($urandom_range(0, 1)), 6'($urandom), 24'($urandom_range(0, 5))};
      if ($urandom_range(0, 19) == 0) cts_n = ~cts_n;
      if (brk_hold > 0) begin
        brk_hold--;
        brk = (brk_hold > 0);
      end else if ($urandom_range(0, 99) < 2) begin
        brk_hold = $urandom_range(1, 10);
        brk      = 1'b1;
      end
      wr   = ($urandom_range(0, 1) == 1);
      data = 8'($urandom);
      tick(1);
    end
    brk   = 1'b0;
    wr    = 1'b0;
    cts_n = 1'b0;
    tick(1);
    wait_idle(200);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
